// File: rtl/serial_div_pkg.sv
// Shared types and helpers for the serial restoring divider.
//   div_state_t : FSM state encoding (IDLE, LOAD, DIV, OUT)
//   cnt_width() : iteration counter width for a given dividend width
package serial_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DIV  = 2'd2,
        OUT  = 2'd3
    } div_state_t;

    // One count per quotient bit, 0 .. op_x_width-1.
    function automatic int cnt_width(input int op_x_width);
        return (op_x_width > 1) ? $clog2(op_x_width) : 1;
    endfunction

endpackage

// File: rtl/counter_clr_en.sv
// Up-counter with synchronous clear and count enable.
//   clk, rst_n : clock, async active-low reset
//   clr_i      : synchronous clear (takes priority over enable_i)
//   enable_i   : increment by one
//   count_o    : current count
module counter_clr_en #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             enable_i,
    output logic [WIDTH-1:0] count_o
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        count_o <= '0;
        else if (clr_i)    count_o <= '0;
        else if (enable_i) count_o <= count_o + 1'b1;
    end

endmodule

// File: rtl/serial_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
//   clk, rst_n  : clock, async active-low reset
//   start       : request, honoured in IDLE or OUT
//   in_x, in_y  : dividend / divisor, stable through the LOAD cycle
//   valid_out   : one-cycle strobe when results are presented
//   quotient    : registered quotient (all ones on divide by zero)
//   remainder   : registered remainder (in_x low bits on divide by zero)
//   div_by_zero : registered flag, qualified by valid_out
module serial_divider
    import serial_div_pkg::*;
#(
    parameter int OP_X_WIDTH = 32,
    parameter int OP_Y_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [OP_X_WIDTH-1:0] in_x,
    input  logic [OP_Y_WIDTH-1:0] in_y,
    output logic                  valid_out,
    output logic [OP_X_WIDTH-1:0] quotient,
    output logic [OP_Y_WIDTH-1:0] remainder,
    output logic                  div_by_zero
);

    localparam int CW = cnt_width(OP_X_WIDTH);

    div_state_t state, state_nxt;

    logic [CW-1:0]         cnt;
    logic [OP_X_WIDTH-1:0] q_reg;
    logic [OP_Y_WIDTH:0]   r_reg;
    logic [OP_Y_WIDTH-1:0] d_reg;

    logic [OP_Y_WIDTH:0]   shifted;
    logic [OP_Y_WIDTH+1:0] trial;
    logic [OP_Y_WIDTH:0]   r_step;
    logic [OP_X_WIDTH-1:0] q_step;
    logic                  last_iter;
    logic                  r_msb_unused;

    // The partial remainder is always below D, so its top bit stays zero;
    // only the low OP_Y_WIDTH bits feed the next shift.
    assign r_msb_unused = r_reg[OP_Y_WIDTH];

    assign last_iter = (state == DIV) && (cnt == CW'(OP_X_WIDTH - 1));

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = LOAD;
            LOAD: state_nxt = (in_y == '0) ? OUT : DIV;
            DIV:  if (last_iter) state_nxt = OUT;
            OUT:  state_nxt = start ? LOAD : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    counter_clr_en #(
        .WIDTH (CW)
    ) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    ((state == LOAD) || (state == OUT)),
        .enable_i (state == DIV),
        .count_o  (cnt)
    );

    // ---------------- iteration datapath ----------------
    // Extra top bit on the subtraction acts as the borrow / sign.
    always_comb begin
        shifted = {r_reg[OP_Y_WIDTH-1:0], q_reg[OP_X_WIDTH-1]};
        trial   = {1'b0, shifted} - {2'b00, d_reg};
        if (trial[OP_Y_WIDTH+1]) begin
            r_step = shifted;
            q_step = {q_reg[OP_X_WIDTH-2:0], 1'b0};
        end else begin
            r_step = trial[OP_Y_WIDTH:0];
            q_step = {q_reg[OP_X_WIDTH-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg <= '0;
            r_reg <= '0;
            d_reg <= '0;
        end else begin
            case (state)
                LOAD: begin
                    q_reg <= in_x;
                    r_reg <= '0;
                    d_reg <= in_y;
                end
                DIV: begin
                    q_reg <= q_step;
                    r_reg <= r_step;
                end
                default: ;
            endcase
        end
    end

    // ---------------- result registers ----------------
    // Captured on the edge entering OUT. The DIV path takes the just-computed
    // step values so the final iteration lands in the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            valid_out <= (state_nxt == OUT);
            if (state == LOAD && state_nxt == OUT) begin
                quotient    <= '1;
                remainder   <= in_x[OP_Y_WIDTH-1:0];
                div_by_zero <= 1'b1;
            end else if (state == DIV && state_nxt == OUT) begin
                quotient    <= q_step;
                remainder   <= r_step[OP_Y_WIDTH-1:0];
                div_by_zero <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_divider.sv
// Directed self-checking bench for serial_divider (32/16 defaults).
module tb_serial_divider;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] in_x;
    logic [15:0] in_y;
    logic        valid_out;
    logic [31:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;

    int n_vec;
    int n_err;

    serial_divider #(
        .OP_X_WIDTH (32),
        .OP_Y_WIDTH (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .in_x        (in_x),
        .in_y        (in_y),
        .valid_out   (valid_out),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Count edges after the current one until valid_out is seen (sampled #1
    // after each edge); returns 999 if it never arrives within the budget.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (1) begin
            @(posedge clk); #1;
            lat++;
            if (valid_out) break;
            if (lat > 120) begin
                lat = 999;
                break;
            end
        end
    endtask

    // Pulse start with operands; returns after the E0 edge (+#1).
    task automatic issue(input logic [31:0] x, input logic [15:0] y);
        start = 1'b1;
        in_x  = x;
        in_y  = y;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [31:0] x, input logic [15:0] y,
                          input logic [31:0] eq, input logic [15:0] er,
                          input logic edz, input int elat);
        int lat;
        issue(x, y);
        wait_valid(lat);
        chk({tag, " latency"}, lat, elat);
        chk({tag, " quotient"}, quotient, eq);
        chk({tag, " remainder"}, {16'h0, remainder}, {16'h0, er});
        chk({tag, " dbz"}, {31'h0, div_by_zero}, {31'h0, edz});
        @(posedge clk); #1;
        chk({tag, " strobe drop"}, {31'h0, valid_out}, 32'h0);
        chk({tag, " hold q"}, quotient, eq);
        chk({tag, " hold r"}, {16'h0, remainder}, {16'h0, er});
    endtask

    initial begin
        int lat;
        int seen;
        logic [31:0] bx [3];
        logic [15:0] by [3];
        logic [31:0] bq [3];
        logic [15:0] br [3];

        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        start = 1'b0;
        in_x  = '0;
        in_y  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset valid", {31'h0, valid_out}, 32'h0);
        chk("reset q", quotient, 32'h0);
        chk("reset r", {16'h0, remainder}, 32'h0);
        chk("reset dbz", {31'h0, div_by_zero}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("100/7",      32'd100,       16'd7,      32'd14,        16'd2,      1'b0, 33);
        run_op("max/max",    32'hFFFFFFFF,  16'hFFFF,   32'h00010001,  16'h0,      1'b0, 33);
        run_op("5/9",        32'd5,         16'd9,      32'd0,         16'd5,      1'b0, 33);
        run_op("x/1",        32'h12345678,  16'd1,      32'h12345678,  16'h0,      1'b0, 33);
        run_op("div0",       32'hDEADBEEF,  16'd0,      32'hFFFFFFFF,  16'hBEEF,   1'b1, 1);

        // Back-to-back with start held; next operands set while in OUT,
        // ahead of the LOAD that follows.
        bx[0] = 32'd1000;      by[0] = 16'd10;  bq[0] = 32'd100;      br[0] = 16'd0;
        bx[1] = 32'hFFFFFFFF;  by[1] = 16'd2;   bq[1] = 32'h7FFFFFFF; br[1] = 16'd1;
        bx[2] = 32'd12345;     by[2] = 16'd100; bq[2] = 32'd123;      br[2] = 16'd45;
        start = 1'b1;
        in_x  = bx[0];
        in_y  = by[0];
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            wait_valid(lat);
            chk($sformatf("b2b%0d interval", k), lat, (k == 0) ? 33 : 34);
            chk($sformatf("b2b%0d q", k), quotient, bq[k]);
            chk($sformatf("b2b%0d r", k), {16'h0, remainder}, {16'h0, br[k]});
            if (k < 2) begin
                in_x = bx[k+1];
                in_y = by[k+1];
            end else begin
                start = 1'b0;
            end
        end
        @(posedge clk); #1;
        @(posedge clk); #1;

        // start pulsed mid-DIV must not restart the operation.
        issue(32'd77, 16'd5);
        lat = 0;
        repeat (10) begin @(posedge clk); #1; lat++; end
        start = 1'b1;
        @(posedge clk); #1; lat++;
        start = 1'b0;
        seen = 0;
        while (!valid_out && lat < 120) begin @(posedge clk); #1; lat++; end
        chk("restart-ignored latency", lat, 33);
        chk("restart-ignored q", quotient, 32'd15);
        chk("restart-ignored r", {16'h0, remainder}, 32'd2);
        repeat (40) begin @(posedge clk); #1; if (valid_out) seen++; end
        chk("restart-ignored no 2nd", seen, 0);

        // Reset mid-DIV aborts with no strobe.
        issue(32'd999, 16'd4);
        repeat (12) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort q", quotient, 32'h0);
        chk("abort r", {16'h0, remainder}, 32'h0);
        chk("abort valid", {31'h0, valid_out}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (valid_out) seen++; end
        chk("abort no strobe", seen, 0);

        run_op("post-reset", 32'd200, 16'd3, 32'd66, 16'd2, 1'b0, 33);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
